// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data SRAM port arbiter.
// Holds the FSM state encoding, bus widths and the kseg0/kseg1 window test.
package sram_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WEN_W  = 4;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_t;

  localparam logic [3:0] KSEG_NIB_LO = 4'h8;
  localparam logic [3:0] KSEG_NIB_HI = 4'hB;

  // kseg0 (0x8/0x9) and kseg1 (0xA/0xB) both fold onto the low 512 MB.
  function automatic logic is_kseg(input logic [3:0] nib);
    return (nib >= KSEG_NIB_LO) && (nib <= KSEG_NIB_HI);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_addr_map.sv
// Combinational virtual-to-physical mapper for the shared SRAM address.
// With mapping disabled the address passes straight through.
module sram_port_arbiter_addr_map
  import sram_port_arbiter_pkg::*;
#(
  parameter bit MAP_EN = 1'b1
) (
  input  logic [ADDR_W-1:0] vaddr,
  output logic [ADDR_W-1:0] paddr
);

  generate
    if (MAP_EN) begin : g_map
      always_comb begin
        paddr = vaddr;
        if (is_kseg(vaddr[ADDR_W-1 -: 4])) begin
          paddr[ADDR_W-1 -: 3] = 3'b000;
        end
      end
    end else begin : g_pass
      assign paddr = vaddr;
    end
  endgenerate

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous single-port SRAM between the instruction and data
// ports; data wins ties and a completing port is never re-granted at once.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter bit MAP_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iram_en,
  input  logic [WEN_W-1:0]  iram_wen,
  input  logic [ADDR_W-1:0] iram_addr,
  input  logic [DATA_W-1:0] iram_wdata,
  output logic [DATA_W-1:0] iram_rdata,
  output logic              iram_wait,
  input  logic              dram_en,
  input  logic [WEN_W-1:0]  dram_wen,
  input  logic [ADDR_W-1:0] dram_addr,
  input  logic [DATA_W-1:0] dram_wdata,
  output logic [DATA_W-1:0] dram_rdata,
  output logic              dram_wait,
  output logic              mem_en,
  output logic [WEN_W-1:0]  mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  arb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic              done_i, done_d;
  logic              issue, cand_i, cand_d, grant;
  logic [ADDR_W-1:0] sel_addr, mapped_addr;

  assign done_i = (state_reg == ST_BUSY_I) && (cnt_reg == '0);
  assign done_d = (state_reg == ST_BUSY_D) && (cnt_reg == '0);

  // A completion cycle doubles as an issue cycle; the completer's en still
  // reflects its old request, so it is excluded from the candidates.
  assign issue  = (state_reg == ST_IDLE) || (cnt_reg == '0);
  assign cand_d = dram_en && !done_d;
  assign cand_i = iram_en && !done_i;
  assign grant  = issue && (cand_d || cand_i);

  assign sel_addr = cand_d ? dram_addr : iram_addr;

  sram_port_arbiter_addr_map #(
    .MAP_EN(MAP_EN)
  ) u_addr_map (
    .vaddr(sel_addr),
    .paddr(mapped_addr)
  );

  // Bus is forced quiet while reset is held, independent of the requesters.
  always_comb begin
    mem_en    = grant && resetn;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_en) begin
      mem_wen   = cand_d ? dram_wen   : iram_wen;
      mem_addr  = mapped_addr;
      mem_wdata = cand_d ? dram_wdata : iram_wdata;
    end
  end

  assign iram_wait  = iram_en && !done_i;
  assign dram_wait  = dram_en && !done_d;
  assign iram_rdata = mem_rdata;
  assign dram_rdata = mem_rdata;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (issue) begin
      if (grant) begin
        state_next = cand_d ? ST_BUSY_D : ST_BUSY_I;
        cnt_next   = CNT_INIT;
      end else begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    end else begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM between the Processor instruction port (iram_*) and data port (dram_*).
- Sits between Processor and a unified memory, the alternative to the current split inst/data SRAM top.
- Sequences each access through a small FSM and drives the Processor's iram_wait/dram_wait stall inputs.
- Optionally applies the kseg0/kseg1 address mapping (top nibble 0x8–0xB -> clear bits [31:29]).

Parameters:
- MEM_LAT, 1, SRAM read latency in cycles from the sampling edge to valid mem_rdata; legal range 1–3.
- MAP_EN, 1, 1 = apply kseg0/kseg1 mapping to mem_addr; 0 = pass the address through unchanged.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- iram_en  in  1  instruction request valid
- iram_wen  in  4  byte write enables (normally 0)
- iram_addr  in  32  instruction virtual address
- iram_wdata  in  32  instruction write data
- iram_rdata  out  32  instruction read data, valid in the completion cycle
- iram_wait  out  1  stall to Processor instruction port
- dram_en  in  1  data request valid
- dram_wen  in  4  data byte write enables
- dram_addr  in  32  data virtual address
- dram_wdata  in  32  data write data
- dram_rdata  out  32  data read data, valid in the completion cycle
- dram_wait  out  1  stall to Processor data port
- mem_en  out  1  SRAM enable
- mem_wen  out  4  SRAM byte write enables
- mem_addr  out  32  mapped physical address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data

Behaviour:
- Requester protocol:
  - A requester holds en/wen/addr/wdata stable while its wait=1.
  - An access completes in the single cycle where en=1 and wait=0; rdata is valid in that cycle.
  - Writes complete with the same timing as reads.
- Wait generation:
  - x_wait = x_en AND NOT done_x, where done_x = (state==BUSY_X AND cnt==0).
  - x_wait = 0 whenever x_en = 0.
- State and counter:
  - FSM states: IDLE, BUSY_I, BUSY_D.
  - cnt is 2 bits wide and counts down while in a BUSY state.
- Issue cycle: the arbiter issues when in IDLE, or in a BUSY state with cnt==0.
  - Candidates are the pending requesters, excluding the one completing this cycle (its en this cycle is its old request).
  - Priority: data over instruction.
  - mem_en=1 and mem_wen/mem_addr/mem_wdata are driven combinationally from the selected requester.
  - At the clock edge: state -> BUSY_sel, cnt <- MEM_LAT-1.
  - If there is no candidate: state -> IDLE and mem_en=0.
- Non-issue cycles: when BUSY with cnt>0, mem_en=0, mem_wen=0 and cnt decrements each cycle.
- Read-data routing: iram_rdata = dram_rdata = mem_rdata at all times; only the wait signals qualify validity.
- Latency:
  - A lone access completes MEM_LAT cycles after issue, so with MEM_LAT=1 a solitary fetch takes 2 cycles (issue, complete).
  - With both ports continuously requesting, grants alternate D, I, D, I...
  - Each completion cycle is also an issue cycle, giving 1 access per MEM_LAT cycles.
- Fairness: the completing port is never re-granted in its own completion cycle, so neither port can starve.
- Address mapping (MAP_EN=1): if addr[31:28] is in 0x8–0xB, mem_addr = {3'b000, addr[28:0]}; otherwise mem_addr = addr. The same rule applies to both ports.
- Reset (resetn low, asynchronous):
  - state=IDLE, cnt=0.
  - While reset is held: mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0.
  - While reset is held, waits follow the en inputs (stall).
- Reset mid-access: the in-flight access is abandoned and no completion is signalled. A write already sampled by the SRAM is not undone.
- Request withdrawn (en dropped while BUSY for that port): illegal by protocol. The arbiter still finishes its count and returns to IDLE without corrupting state.

Decomposition:
- Shared package (defines.v): state encodings ST_IDLE/ST_BUSY_I/ST_BUSY_D, and the kseg mapping nibble constants 4'h8–4'hB. The existing AddrBus/DataBus/WriteEn widths are reused.
- One natural sub-module: addr_map, a combinational kseg mapper instantiated once on the selected address.

Test Plan:
- Lone fetch, MEM_LAT=1: iram_en=1, iram_addr=0xBFC00000 at cycle 0 -> mem_en=1, mem_addr=0x1FC00000 in cycle 0; iram_wait=0 and iram_rdata=mem_rdata in cycle 1; iram_wait=1 in cycle 0.
- Simultaneous requests: iram_en=dram_en=1 in cycle 0 -> D issued in cycle 0 and completes in cycle 1; I issued in cycle 1 and completes in cycle 2; iram_wait is 1 in cycles 0–1.
- Continuous contention for 10 cycles -> grant sequence D,I,D,I...; each port completes every 2nd cycle; mem_en=1 every cycle.
- Byte store: dram_wen=4'b0011, dram_addr=0x80001004, dram_wdata=0x1234ABCD -> mem_wen=4'b0011, mem_addr=0x00001004 for one cycle; dram_wait=0 the next cycle.
- MEM_LAT=3, MAP_EN=0: fetch of 0xBFC00000 -> mem_addr=0xBFC00000; mem_en=1 only in the issue cycle; completion 3 cycles later; iram_wait=1 for cycles 0–2.
- Asynchronous reset asserted in BUSY_D with cnt=1 -> mem_en=0 immediately; after release, state is IDLE and the held dram_en re-issues the access, which completes normally.
